// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for base^exp mod n.
// Every reduction is offloaded to a shared reducer over a four-phase req/done handshake.
module modexp_ctrl #(
    parameter int EXP_W = 32,
    parameter int MOD_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [EXP_W-1:0] exp,
    input  logic [MOD_W-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [MOD_W-1:0] result,
    output logic             mod_req,
    output logic [31:0]      mod_num,
    output logic [31:0]      mod_den,
    input  logic             mod_done,
    input  logic [31:0]      mod_result
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RED_B    = 3'd1;
    localparam logic [2:0] CHECK    = 3'd2;
    localparam logic [2:0] MUL      = 3'd3;
    localparam logic [2:0] SQR      = 3'd4;
    localparam logic [2:0] WAIT_LOW = 3'd5;
    localparam logic [2:0] FIN      = 3'd6;

    localparam logic [MOD_W-1:0] MOD_ONE  = {{(MOD_W-1){1'b0}}, 1'b1};
    localparam logic [MOD_W-1:0] MOD_ZERO = '0;

    logic [2:0]       state_reg;
    logic [2:0]       pend_reg;
    logic [MOD_W-1:0] b_reg;
    logic [MOD_W-1:0] r_reg;
    logic [EXP_W-1:0] e_reg;
    logic [MOD_W-1:0] result_reg;
    logic             err_reg;
    logic             mod_req_reg;
    logic [31:0]      mod_num_reg;
    logic [31:0]      mod_den_reg;

    logic [31:0]      sq_prod;
    logic [31:0]      mul_prod;
    logic [MOD_W-1:0] captured;
    logic             unused_bits;

    // Full-width products: operands are < n < 2^MOD_W, so nothing is lost.
    assign sq_prod     = 32'(b_reg) * 32'(b_reg);
    assign mul_prod    = 32'(r_reg) * 32'(b_reg);
    assign captured    = mod_result[MOD_W-1:0];
    assign unused_bits = ^mod_result[31:MOD_W];

    assign busy    = (state_reg != IDLE) && (state_reg != FIN);
    assign done    = (state_reg == FIN);
    assign err     = err_reg;
    assign result  = result_reg;
    assign mod_req = mod_req_reg;
    assign mod_num = mod_num_reg;
    assign mod_den = mod_den_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pend_reg    <= IDLE;
            b_reg       <= '0;
            r_reg       <= '0;
            e_reg       <= '0;
            result_reg  <= '0;
            err_reg     <= 1'b0;
            mod_req_reg <= 1'b0;
            mod_num_reg <= '0;
            mod_den_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mod_den_reg <= 32'(n);
                        if (n == MOD_ZERO) begin
                            err_reg    <= 1'b1;
                            result_reg <= '0;
                            state_reg  <= FIN;
                        end else begin
                            err_reg     <= 1'b0;
                            e_reg       <= exp;
                            r_reg       <= (n == MOD_ONE) ? MOD_ZERO : MOD_ONE;
                            mod_num_reg <= base;
                            mod_req_reg <= 1'b1;
                            state_reg   <= RED_B;
                        end
                    end
                end
                RED_B: begin
                    if (mod_done) begin
                        b_reg       <= captured;
                        mod_req_reg <= 1'b0;
                        pend_reg    <= CHECK;
                        state_reg   <= WAIT_LOW;
                    end
                end
                CHECK: begin
                    if (e_reg == '0) begin
                        result_reg <= r_reg;
                        state_reg  <= FIN;
                    end else if (e_reg[0]) begin
                        mod_num_reg <= mul_prod;
                        mod_req_reg <= 1'b1;
                        state_reg   <= MUL;
                    end else begin
                        mod_num_reg <= sq_prod;
                        mod_req_reg <= 1'b1;
                        state_reg   <= SQR;
                    end
                end
                MUL: begin
                    if (mod_done) begin
                        r_reg       <= captured;
                        mod_req_reg <= 1'b0;
                        state_reg   <= WAIT_LOW;
                        // Last exponent bit consumed: skip the useless final squaring.
                        if ((e_reg >> 1) == '0) begin
                            e_reg    <= '0;
                            pend_reg <= CHECK;
                        end else begin
                            pend_reg <= SQR;
                        end
                    end
                end
                SQR: begin
                    if (mod_done) begin
                        b_reg       <= captured;
                        e_reg       <= e_reg >> 1;
                        mod_req_reg <= 1'b0;
                        pend_reg    <= CHECK;
                        state_reg   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!mod_done) begin
                        state_reg <= pend_reg;
                        if (pend_reg == SQR) begin
                            mod_num_reg <= sq_prod;
                            mod_req_reg <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: random-latency reducer model, protocol monitor,
// and a left-to-right modular exponentiation reference.
module tb_modexp_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base;
    logic [31:0] exp;
    logic [15:0] n;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic        mod_req;
    logic [31:0] mod_num;
    logic [31:0] mod_den;
    logic        mod_done;
    logic [31:0] mod_result;

    int n_checks = 0;
    int n_pass   = 0;

    int          req_rises = 0;
    int          done_cnt  = 0;
    int          proto_err = 0;
    logic        req_prev  = 1'b0;
    logic [31:0] num_prev  = '0;
    logic [15:0] cur_n     = '0;

    int ph  = 0;
    int cnt = 0;

    modexp_ctrl #(.EXP_W(32), .MOD_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .exp        (exp),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .mod_req    (mod_req),
        .mod_num    (mod_num),
        .mod_den    (mod_den),
        .mod_done   (mod_done),
        .mod_result (mod_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reducer: random 1-20 cycle latency, done held 0-5 cycles after req drops.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_done   <= 1'b0;
            mod_result <= '0;
            ph = 0;
            cnt = 0;
        end else begin
            case (ph)
                0: if (mod_req) begin cnt = int'($urandom_range(1, 20)); ph = 1; end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        mod_done   <= 1'b1;
                        mod_result <= (mod_den == 0) ? 32'd0 : (mod_num % mod_den);
                        ph = 2;
                    end
                end
                2: if (!mod_req) begin
                    cnt = int'($urandom_range(0, 5));
                    mod_result <= $urandom;
                    if (cnt == 0) begin mod_done <= 1'b0; ph = 0; end
                    else ph = 3;
                end
                default: begin
                    cnt--;
                    if (cnt == 0) begin mod_done <= 1'b0; ph = 0; end
                end
            endcase
        end
    end

    // Handshake monitor: no req while done still high, stable numerator, correct denominator.
    always @(negedge clk) begin
        if (mod_req && !req_prev) begin
            req_rises++;
            if (mod_done) proto_err++;
            if (mod_den !== {16'b0, cur_n}) proto_err++;
        end
        if (mod_req && req_prev && (mod_num !== num_prev)) proto_err++;
        if (done) done_cnt++;
        req_prev = mod_req;
        num_prev = mod_num;
    end

    function automatic logic [15:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                               input logic [15:0] m);
        longint unsigned acc;
        longint unsigned bb;
        if (m == 0) return 16'd0;
        acc = 64'd1 % m;
        bb  = b % m;
        for (int i = 31; i >= 0; i--) begin
            acc = (acc * acc) % m;
            if (e[i]) acc = (acc * bb) % m;
        end
        return 16'(acc);
    endfunction

    function automatic int ref_reductions(input logic [31:0] e);
        int bl = 0;
        for (int i = 0; i < 32; i++) if (e[i]) bl = i + 1;
        return 1 + $countones(e) + ((bl > 1) ? bl - 1 : 0);
    endfunction

    task automatic do_op(input logic [31:0] b, input logic [31:0] e, input logic [15:0] nn,
                         input bit poke, output logic [15:0] res, output logic er,
                         output int reqs, output int dones, output bit tmo,
                         output logic busy1, output logic err1);
        int r0;
        int d0;
        @(negedge clk);
        r0 = req_rises;
        d0 = done_cnt;
        base = b; exp = e; n = nn; cur_n = nn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        err1  = err;
        tmo   = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if (done) begin tmo = 1'b0; break; end
            if (poke && $urandom_range(0, 7) == 0) begin
                start = 1'b1; base = $urandom; exp = $urandom; n = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        res = result;
        er  = err;
        @(negedge clk);
        @(negedge clk);
        #1;
        reqs  = req_rises - r0;
        dones = done_cnt - d0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else n_pass++;
        n_checks++; if (mod_req !== 1'b0) $display("FAIL reset_mod_req got=%b want=0", mod_req); else n_pass++;
        n_checks++; if (result !== 16'd0) $display("FAIL reset_result got=%0d want=0", result); else n_pass++;
        n_checks++; if (mod_num !== 32'd0) $display("FAIL reset_mod_num got=%0d want=0", mod_num); else n_pass++;
        n_checks++; if (mod_den !== 32'd0) $display("FAIL reset_mod_den got=%0d want=0", mod_den); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else n_pass++;
        $display("reset: outputs checked");
    endtask

    task automatic test_known();
        logic [31:0] kb[4];
        logic [31:0] ke[4];
        logic [15:0] kn[4];
        logic [15:0] kr[4];
        int          kq[4];
        logic [15:0] res;
        logic        er, busy1, err1;
        int          reqs, dones;
        bit          tmo;
        kb = '{32'd4, 32'd1000, 32'd5, 32'd7};
        ke = '{32'd13, 32'd2, 32'd0, 32'd5};
        kn = '{16'd497, 16'd7, 16'd7, 16'd1};
        kr = '{16'd445, 16'd1, 16'd1, 16'd0};
        kq = '{7, 3, 1, 5};
        for (int i = 0; i < 4; i++) begin
            do_op(kb[i], ke[i], kn[i], 1'b0, res, er, reqs, dones, tmo, busy1, err1);
            n_checks++; if (tmo) $display("FAIL known%0d_timeout got=no_done want=done", i); else n_pass++;
            n_checks++; if (res !== kr[i]) $display("FAIL known%0d_result got=%0d want=%0d", i, res, kr[i]); else n_pass++;
            n_checks++; if (result !== kr[i]) $display("FAIL known%0d_held got=%0d want=%0d", i, result, kr[i]); else n_pass++;
            n_checks++; if (er !== 1'b0) $display("FAIL known%0d_err got=%b want=0", i, er); else n_pass++;
            n_checks++; if (reqs != kq[i]) $display("FAIL known%0d_reqs got=%0d want=%0d", i, reqs, kq[i]); else n_pass++;
            n_checks++; if (dones != 1) $display("FAIL known%0d_dones got=%0d want=1", i, dones); else n_pass++;
            n_checks++; if (busy1 !== 1'b1) $display("FAIL known%0d_busy got=%b want=1", i, busy1); else n_pass++;
            $display("known: %0d^%0d mod %0d -> %0d (%0d reductions)", kb[i], ke[i], kn[i], res, reqs);
        end
    endtask

    task automatic test_mod_zero();
        int          r0;
        int          d0;
        logic [15:0] res;
        logic        er, busy1, err1;
        int          reqs, dones;
        bit          tmo;
        @(negedge clk);
        r0 = req_rises;
        d0 = done_cnt;
        base = $urandom; exp = $urandom; n = 16'd0; cur_n = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL zero_done got=%b want=1", done); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL zero_err got=%b want=1", err); else n_pass++;
        n_checks++; if (result !== 16'd0) $display("FAIL zero_result got=%0d want=0", result); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got=%b want=0", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL zero_pulse got=%b want=0", done); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL zero_err_held got=%b want=1", err); else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_rises != r0) $display("FAIL zero_no_req got=%0d want=0", req_rises - r0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL zero_dones got=%0d want=1", done_cnt - d0); else n_pass++;
        $display("mod_zero: n=0 -> err=1 result=0");
        do_op(32'd3, 32'd3, 16'd7, 1'b0, res, er, reqs, dones, tmo, busy1, err1);
        n_checks++; if (err1 !== 1'b0) $display("FAIL zero_clear got=%b want=0", err1); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL zero_after_err got=%b want=0", er); else n_pass++;
        n_checks++; if (res !== 16'd6) $display("FAIL zero_after_result got=%0d want=6", res); else n_pass++;
        $display("mod_zero: 3^3 mod 7 -> %0d err=%b", res, er);
    endtask

    task automatic test_random();
        logic [31:0] b, e;
        logic [15:0] m, want;
        logic [15:0] res;
        logic        er, busy1, err1;
        int          reqs, dones, w, p0;
        bit          tmo;
        p0 = proto_err;
        for (int i = 0; i < 200; i++) begin
            b = $urandom;
            m = 16'($urandom_range(2, 65535));
            if (i < 4) begin
                e = $urandom;
            end else begin
                w = int'($urandom_range(0, 10));
                e = $urandom & ((32'd1 << w) - 32'd1);
            end
            want = ref_modexp(b, e, m);
            do_op(b, e, m, 1'b1, res, er, reqs, dones, tmo, busy1, err1);
            n_checks++; if (tmo) $display("FAIL rand%0d_timeout got=no_done want=done", i); else n_pass++;
            n_checks++; if (res !== want) $display("FAIL rand%0d_result got=%0d want=%0d", i, res, want); else n_pass++;
            n_checks++; if (er !== 1'b0) $display("FAIL rand%0d_err got=%b want=0", i, er); else n_pass++;
            n_checks++; if (reqs != ref_reductions(e)) $display("FAIL rand%0d_reqs got=%0d want=%0d", i, reqs, ref_reductions(e)); else n_pass++;
            n_checks++; if (dones != 1) $display("FAIL rand%0d_dones got=%0d want=1", i, dones); else n_pass++;
            $display("rand %0d: %0d^%0d mod %0d -> %0d", i, b, e, m, res);
        end
        n_checks++; if (proto_err != p0) $display("FAIL rand_protocol got=%0d want=0 violations", proto_err - p0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int r0;
        bit seen;
        @(negedge clk);
        base = 32'd2; exp = 32'd10; n = 16'd1000; cur_n = 16'd1000; start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL b2b_first_timeout got=no_done want=done"); else n_pass++;
        n_checks++; if (result !== 16'd24) $display("FAIL b2b_first got=%0d want=24", result); else n_pass++;
        base = 32'd3; exp = 32'd4; n = 16'd50; cur_n = 16'd50;
        @(negedge clk);
        r0 = req_rises;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_retrigger got=%b want=1", busy); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (done) seen = 1'b1; else @(negedge clk);
        end
        n_checks++; if (!seen) $display("FAIL b2b_second_timeout got=no_done want=done"); else n_pass++;
        n_checks++; if (result !== 16'd31) $display("FAIL b2b_second got=%0d want=31", result); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (req_rises - r0 != 4) $display("FAIL b2b_reqs got=%0d want=4", req_rises - r0); else n_pass++;
        $display("back_to_back: 24 then %0d", result);
    endtask

    task automatic test_reset_mid_mul();
        int          r0;
        bit          found;
        logic [15:0] res;
        logic        er, busy1, err1;
        int          reqs, dones;
        bit          tmo;
        @(negedge clk);
        r0 = req_rises;
        base = 32'd4; exp = 32'd13; n = 16'd497; cur_n = 16'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            #1;
            if ((req_rises - r0 >= 2) && mod_req) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL mid_mul_reach got=not_reached want=mul_req"); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (mod_req !== 1'b0) $display("FAIL mid_reset_req got=%b want=0", mod_req); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL mid_reset_done got=%b want=0", done); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(32'd4, 32'd13, 16'd497, 1'b0, res, er, reqs, dones, tmo, busy1, err1);
        n_checks++; if (res !== 16'd445) $display("FAIL mid_after_result got=%0d want=445", res); else n_pass++;
        n_checks++; if (reqs != 7) $display("FAIL mid_after_reqs got=%0d want=7", reqs); else n_pass++;
        $display("reset_mid_mul: restart -> %0d", res);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        n     = '0;
        #1 reset = 1'b1;
        test_reset();
        test_known();
        test_mod_zero();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        n_checks++; if (proto_err != 0) $display("FAIL protocol got=%0d want=0 violations", proto_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
